// File: rtl/acore_debug_intf.sv
// acore_debug_intf: JTAG-side debug register block for the analog core.
// Word-addressed register file with registered one-cycle read data, address
// error pulses, CDR PI override controls and a programmable debug clock.
module acore_debug_intf #(
  parameter logic [31:0] ID_VALUE = 32'h0000_0001,
  parameter int          ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  output logic [31:0]       rdata,
  output logic              rd_valid,
  output logic              addr_err,
  output logic [15:0]       acore_ctrl,
  input  logic [15:0]       acore_stat,
  output logic [7:0]        cdr_pi_ext,
  output logic              cdr_ext_en,
  input  logic [7:0]        cdr_pi_stat,
  output logic              dbg_clk
);

  localparam logic [ADDR_W-1:0] ADDR_ID         = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ACORE_CTRL = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ACORE_STAT = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_CDR_CTRL   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_CDR_STAT   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_CLK_CFG    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH    = ADDR_W'(6);

  // Configuration state
  logic [7:0]  clk_div;
  logic [7:0]  clk_high;
  logic        clk_en;
  logic [31:0] scratch;
  logic [7:0]  clk_cnt;

  // Decoded accesses and next-state values for the clock generator
  logic        addr_mapped;
  logic [31:0] rd_mux;
  logic        cfg_wr;
  logic [7:0]  div_eff;
  logic [7:0]  high_next;
  logic        en_next;
  logic [7:0]  cnt_next;
  logic        dbg_next;

  // Read multiplexer: current (pre-write) register contents, status sampled live
  always_comb begin
    rd_mux      = 32'h0;
    addr_mapped = 1'b1;
    case (addr)
      ADDR_ID:         rd_mux = ID_VALUE;
      ADDR_ACORE_CTRL: rd_mux = {16'h0, acore_ctrl};
      ADDR_ACORE_STAT: rd_mux = {16'h0, acore_stat};
      ADDR_CDR_CTRL:   rd_mux = {23'h0, cdr_ext_en, cdr_pi_ext};
      ADDR_CDR_STAT:   rd_mux = {24'h0, cdr_pi_stat};
      ADDR_CLK_CFG:    rd_mux = {15'h0, clk_en, clk_high, clk_div};
      ADDR_SCRATCH:    rd_mux = scratch;
      default: begin
        rd_mux      = 32'h0;
        addr_mapped = 1'b0;
      end
    endcase
  end

  // Debug clock next state: a CLK_CFG write restarts the counter at 0 and the
  // registered output is computed from the counter value it will hold next
  always_comb begin
    cfg_wr    = wr_en && (addr == ADDR_CLK_CFG);
    en_next   = cfg_wr ? wdata[16]    : clk_en;
    high_next = cfg_wr ? wdata[15:8]  : clk_high;
    div_eff   = (clk_div == 8'd0) ? 8'd1 : clk_div;
    cnt_next  = 8'd0;
    if (!cfg_wr && clk_en && (clk_cnt < div_eff - 8'd1)) begin
      cnt_next = clk_cnt + 8'd1;
    end
    // The counter never reaches P, so cnt < high is the same as cnt < min(high, P)
    dbg_next = en_next && (cnt_next < high_next);
  end

  // Register writes; read-only and unmapped addresses simply match nothing
  always_ff @(posedge clk) begin
    if (rstb) begin
      acore_ctrl <= 16'h0;
      cdr_pi_ext <= 8'h0;
      cdr_ext_en <= 1'b0;
      clk_div    <= 8'd1;
      clk_high   <= 8'd0;
      clk_en     <= 1'b0;
      scratch    <= 32'h0;
    end else if (wr_en) begin
      case (addr)
        ADDR_ACORE_CTRL: acore_ctrl <= wdata[15:0];
        ADDR_CDR_CTRL: begin
          cdr_pi_ext <= wdata[7:0];
          cdr_ext_en <= wdata[8];
        end
        ADDR_CLK_CFG: begin
          clk_div  <= wdata[7:0];
          clk_high <= wdata[15:8];
          clk_en   <= wdata[16];
        end
        ADDR_SCRATCH: scratch <= wdata;
        default: ;
      endcase
    end
  end

  // Read response and address-error pulse; rdata holds between reads
  always_ff @(posedge clk) begin
    if (rstb) begin
      rdata    <= 32'h0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      addr_err <= (rd_en || wr_en) && !addr_mapped;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

  // Debug clock counter and registered output
  always_ff @(posedge clk) begin
    if (rstb) begin
      clk_cnt <= 8'd0;
      dbg_clk <= 1'b0;
    end else begin
      clk_cnt <= cnt_next;
      dbg_clk <= dbg_next;
    end
  end

endmodule

// File: tb/tb_acore_debug_intf.sv
// tb_acore_debug_intf: directed scenarios followed by randomized accesses,
// all outputs checked every cycle against a register-map level model.
module tb_acore_debug_intf;

  logic        clk = 1'b0;
  logic        rstb;
  logic [7:0]  addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic        rd_en;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        addr_err;
  logic [15:0] acore_ctrl;
  logic [15:0] acore_stat;
  logic [7:0]  cdr_pi_ext;
  logic        cdr_ext_en;
  logic [7:0]  cdr_pi_stat;
  logic        dbg_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents and cycles elapsed since clock restart
  logic [15:0] m_acore;
  logic [7:0]  m_pi;
  logic        m_ext;
  logic [7:0]  m_div;
  logic [7:0]  m_high;
  logic        m_en;
  logic [31:0] m_scratch;
  int          m_elapsed;
  logic [31:0] e_rdata;
  logic        e_rd_valid;
  logic        e_addr_err;

  acore_debug_intf #(.ID_VALUE(32'h0000_0001), .ADDR_W(8)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .addr        (addr),
    .wr_en       (wr_en),
    .wdata       (wdata),
    .rd_en       (rd_en),
    .rdata       (rdata),
    .rd_valid    (rd_valid),
    .addr_err    (addr_err),
    .acore_ctrl  (acore_ctrl),
    .acore_stat  (acore_stat),
    .cdr_pi_ext  (cdr_pi_ext),
    .cdr_ext_en  (cdr_ext_en),
    .cdr_pi_stat (cdr_pi_stat),
    .dbg_clk     (dbg_clk)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [31:0] modelRead(input logic [7:0] a);
    case (a)
      8'd0:    return 32'h0000_0001;
      8'd1:    return {16'h0, m_acore};
      8'd2:    return {16'h0, acore_stat};
      8'd3:    return {23'h0, m_ext, m_pi};
      8'd4:    return {24'h0, cdr_pi_stat};
      8'd5:    return {15'h0, m_en, m_high, m_div};
      8'd6:    return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic modelDbg();
    int period;
    period = (m_div == 8'd0) ? 1 : int'(m_div);
    return m_en && ((m_elapsed % period) < int'(m_high));
  endfunction

  task automatic modelEdge(input logic r, input logic [7:0] a, input logic w,
                           input logic [31:0] d, input logic rd);
    if (r) begin
      m_acore = 16'h0; m_pi = 8'h0; m_ext = 1'b0;
      m_div = 8'd1; m_high = 8'd0; m_en = 1'b0;
      m_scratch = 32'h0; m_elapsed = 0;
      e_rdata = 32'h0; e_rd_valid = 1'b0; e_addr_err = 1'b0;
    end else begin
      e_rd_valid = rd;
      e_addr_err = (rd || w) && (a > 8'd6);
      if (rd) e_rdata = modelRead(a);
      m_elapsed = m_elapsed + 1;
      if (w) begin
        case (a)
          8'd1: m_acore = d[15:0];
          8'd3: begin m_pi = d[7:0]; m_ext = d[8]; end
          8'd5: begin m_div = d[7:0]; m_high = d[15:8]; m_en = d[16]; m_elapsed = 0; end
          8'd6: m_scratch = d;
          default: ;
        endcase
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    checkValue("rdata",      rdata,                e_rdata);
    checkValue("rd_valid",   {31'h0, rd_valid},    {31'h0, e_rd_valid});
    checkValue("addr_err",   {31'h0, addr_err},    {31'h0, e_addr_err});
    checkValue("acore_ctrl", {16'h0, acore_ctrl},  {16'h0, m_acore});
    checkValue("cdr_pi_ext", {24'h0, cdr_pi_ext},  {24'h0, m_pi});
    checkValue("cdr_ext_en", {31'h0, cdr_ext_en},  {31'h0, m_ext});
    checkValue("dbg_clk",    {31'h0, dbg_clk},     {31'h0, modelDbg()});
  endtask

  // One clock of stimulus: drive, let the edge happen, update model, compare
  task automatic applyStimulus(input logic r, input logic [7:0] a, input logic w,
                               input logic [31:0] d, input logic rd);
    rstb = r; addr = a; wr_en = w; wdata = d; rd_en = rd;
    @(posedge clk);
    modelEdge(r, a, w, d, rd);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic        r_r, r_w, r_rd;
    logic [7:0]  r_a;
    logic [31:0] r_d;

    rstb = 1'b1; addr = 8'h0; wr_en = 1'b0; wdata = 32'h0; rd_en = 1'b0;
    acore_stat = 16'h0; cdr_pi_stat = 8'h0;
    modelEdge(1'b1, 8'h0, 1'b0, 32'h0, 1'b0);

    // Reset, with a write attempted during reset that must be dropped
    applyStimulus(1'b1, 8'h06, 1'b1, 32'h1234_5678, 1'b1);
    applyStimulus(1'b1, 8'h01, 1'b1, 32'hFFFF_FFFF, 1'b0);
    checkValue("reset_rdata", rdata, 32'h0);
    checkValue("reset_acore", {16'h0, acore_ctrl}, 32'h0);
    checkValue("reset_dbg", {31'h0, dbg_clk}, 32'h0);

    // ID read and hold of rdata afterwards
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
    checkValue("id_read", rdata, 32'h0000_0001);
    checkValue("id_valid", {31'h0, rd_valid}, 32'h1);
    idle();
    checkValue("id_hold", rdata, 32'h0000_0001);
    checkValue("valid_pulse", {31'h0, rd_valid}, 32'h0);

    // ACORE_CTRL with unused upper bits
    applyStimulus(1'b0, 8'h01, 1'b1, 32'hFFFF_A5A5, 1'b0);
    checkValue("acore_out", {16'h0, acore_ctrl}, 32'h0000_A5A5);
    applyStimulus(1'b0, 8'h01, 1'b0, 32'h0, 1'b1);
    checkValue("acore_read", rdata, 32'h0000_A5A5);

    // CDR control and status
    applyStimulus(1'b0, 8'h03, 1'b1, 32'h0000_0117, 1'b0);
    checkValue("pi_ext", {24'h0, cdr_pi_ext}, 32'h17);
    checkValue("ext_en", {31'h0, cdr_ext_en}, 32'h1);
    cdr_pi_stat = 8'h3C;
    applyStimulus(1'b0, 8'h04, 1'b0, 32'h0, 1'b1);
    checkValue("cdr_stat", rdata, 32'h0000_003C);

    // Debug clock div=4 high=2: 1,1,0,0 repeating, then high=0
    applyStimulus(1'b0, 8'h05, 1'b1, 32'h0001_0204, 1'b0);
    checkValue("dbg_pat0", {31'h0, dbg_clk}, 32'h1);
    for (int i = 1; i < 9; i++) begin
      idle();
      checkValue("dbg_pat", {31'h0, dbg_clk}, ((i % 4) < 2) ? 32'h1 : 32'h0);
    end
    applyStimulus(1'b0, 8'h05, 1'b1, 32'h0001_0004, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle();
      checkValue("dbg_high0", {31'h0, dbg_clk}, 32'h0);
    end

    // Unmapped read and write to a read-only register
    applyStimulus(1'b0, 8'h10, 1'b0, 32'h0, 1'b1);
    checkValue("unmapped_rdata", rdata, 32'h0);
    checkValue("unmapped_err", {31'h0, addr_err}, 32'h1);
    checkValue("unmapped_valid", {31'h0, rd_valid}, 32'h1);
    idle();
    checkValue("err_pulse", {31'h0, addr_err}, 32'h0);
    acore_stat = 16'h1234;
    applyStimulus(1'b0, 8'h02, 1'b1, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, 8'h02, 1'b0, 32'h0, 1'b1);
    checkValue("stat_ro", rdata, 32'h0000_1234);

    // Simultaneous read/write of SCRATCH, then reset clears it
    applyStimulus(1'b0, 8'h06, 1'b1, 32'hDEAD_BEEF, 1'b1);
    checkValue("rw_old", rdata, 32'h0);
    applyStimulus(1'b0, 8'h06, 1'b0, 32'h0, 1'b1);
    checkValue("rw_new", rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 8'h06, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 8'h06, 1'b0, 32'h0, 1'b1);
    checkValue("scratch_reset", rdata, 32'h0);

    // Randomized accesses checked against the model every cycle
    for (int n = 0; n < 800; n++) begin
      acore_stat  = 16'($urandom);
      cdr_pi_stat = 8'($urandom);
      r_r  = ($urandom_range(0, 39) == 0);
      r_a  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(7, 255))
                                          : 8'($urandom_range(0, 6));
      r_w  = 1'($urandom_range(0, 1));
      r_rd = 1'($urandom_range(0, 1));
      r_d  = $urandom;
      if (r_a == 8'd5) begin
        if ($urandom_range(0, 3) != 0) r_w = ($urandom_range(0, 5) == 0);
        r_d[7:0]  = 8'($urandom_range(0, 6));
        r_d[15:8] = 8'($urandom_range(0, 7));
        r_d[16]   = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(r_r, r_a, r_w, r_d, r_rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
